// File: rtl/tt_vector_sweep_checker.sv
// rtl/tt_vector_sweep_checker.sv - exhaustive input sweep and truth-table response checker
module tt_vector_sweep_checker #(
  parameter int N_IN = 3,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'hE8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_resp,
  output logic [N_IN-1:0] stim_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  state_t          state, state_n;
  logic [3:0]      hold_cnt, hold_cnt_n;
  logic [N_IN-1:0] stim_n, ffvec_n;
  logic [N_IN:0]   err_n;
  logic            ffv_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      stim_out         <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      state            <= state_n;
      hold_cnt         <= hold_cnt_n;
      stim_out         <= stim_n;
      err_count        <= err_n;
      first_fail_valid <= ffv_n;
      first_fail_vec   <= ffvec_n;
    end
  end

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    stim_n     = stim_out;
    err_n      = err_count;
    ffv_n      = first_fail_valid;
    ffvec_n    = first_fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n    = HOLD;
          hold_cnt_n = '0;
          stim_n     = '0;
          err_n      = '0;
          ffv_n      = 1'b0;
          ffvec_n    = '0;
        end
      end
      HOLD: begin
        if (hold_cnt < SETTLE_L) begin
          hold_cnt_n = hold_cnt + 4'd1;
        end else begin
          // Sample point: last cycle of this vector's hold window
          if (dut_resp != EXPECTED[stim_out]) begin
            err_n = err_count + 1'b1;
            if (!first_fail_valid) begin
              ffv_n   = 1'b1;
              ffvec_n = stim_out;
            end
          end
          if (stim_out != LAST_VEC) begin
            stim_n     = stim_out + 1'b1;
            hold_cnt_n = '0;
          end else begin
            state_n = DONE;
            stim_n  = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == HOLD);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_tt_vector_sweep_checker.sv
// tb/tb_tt_vector_sweep_checker.sv - directed bench for tt_vector_sweep_checker
module tb_tt_vector_sweep_checker;

  logic       clk = 1'b0;
  logic       rst, start, dut_resp;
  logic [2:0] stim_out, first_fail_vec;
  logic       busy, done, pass, first_fail_valid;
  logic [3:0] err_count;

  logic       s0_rst, s0_start, s0_resp;
  logic [2:0] s0_stim, s0_ffvec;
  logic       s0_busy, s0_done, s0_pass, s0_ffv;
  logic [3:0] s0_err;

  int mode;
  int n_checks = 0;
  int n_errors = 0;
  int cycles, walk_err, first_done;

  always #5 clk = ~clk;

  tt_vector_sweep_checker #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hE8)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_resp(dut_resp),
    .stim_out(stim_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_valid(first_fail_valid),
    .first_fail_vec(first_fail_vec)
  );

  tt_vector_sweep_checker #(.N_IN(3), .SETTLE(0), .EXPECTED(8'hE8)) dut_s0 (
    .clk(clk), .rst(s0_rst), .start(s0_start), .dut_resp(s0_resp),
    .stim_out(s0_stim), .busy(s0_busy), .done(s0_done), .pass(s0_pass),
    .err_count(s0_err), .first_fail_valid(s0_ffv),
    .first_fail_vec(s0_ffvec)
  );

  function automatic logic majority(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // mode 0: majority, 1: inverted majority, 2: majority faulted at vectors 5 and 6
  always_comb begin
    dut_resp = majority(stim_out);
    if (mode == 1) dut_resp = ~majority(stim_out);
    else if (mode == 2 && (stim_out == 3'd5 || stim_out == 3'd6)) dut_resp = ~majority(stim_out);
  end

  assign s0_resp = majority(s0_stim);

  task automatic run_sweep(input int start_at, input int rst_at);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    walk_err = 0;
    first_done = int'(done);
    while (busy === 1'b1 && cycles < 100) begin
      if (int'(stim_out) != cycles / 3) walk_err++;
      cycles++;
      start = (cycles == start_at);
      rst   = (cycles == rst_at);
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic check_result(input string tag, input int exp_err, input int exp_ffv,
                              input int exp_vec);
    n_checks++;
    if (cycles !== 24) begin
      n_errors++;
      $display("FAIL %s busy_cycles: got %0d want 24", tag, cycles);
    end
    n_checks++;
    if (walk_err !== 0) begin
      n_errors++;
      $display("FAIL %s stim_walk: got %0d bad samples want 0", tag, walk_err);
    end
    n_checks++;
    if (done !== 1'b1 || pass !== (exp_err == 0)) begin
      n_errors++;
      $display("FAIL %s done_pass: got done=%b pass=%b want done=1 pass=%b", tag, done, pass,
               exp_err == 0);
    end
    n_checks++;
    if (int'(err_count) != exp_err || int'(first_fail_valid) != exp_ffv) begin
      n_errors++;
      $display("FAIL %s err: got err_count=%0d ffv=%b want %0d %0d", tag, err_count,
               first_fail_valid, exp_err, exp_ffv);
    end
    if (exp_ffv == 1) begin
      n_checks++;
      if (int'(first_fail_vec) != exp_vec) begin
        n_errors++;
        $display("FAIL %s first_fail_vec: got %0d want %0d", tag, first_fail_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    s0_rst = 1'b1;
    s0_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || stim_out !== 3'd0 ||
        err_count !== 4'd0 || first_fail_valid !== 1'b0 || first_fail_vec !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_state: got busy=%b done=%b pass=%b stim=%0d err=%0d ffv=%b vec=%0d want all 0",
               busy, done, pass, stim_out, err_count, first_fail_valid, first_fail_vec);
    end
    rst = 1'b0;
    start = 1'b0;
    s0_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_hold: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_majority();
    mode = 0;
    run_sweep(0, 0);
    check_result("majority", 0, 0, 0);
  endtask

  task automatic test_inverted();
    mode = 1;
    run_sweep(0, 0);
    n_checks++;
    if (first_done !== 0) begin
      n_errors++;
      $display("FAIL restart_clears_done: got done=%0d want 0", first_done);
    end
    check_result("inverted", 8, 1, 0);
  endtask

  task automatic test_fault_5_6();
    mode = 2;
    run_sweep(0, 0);
    check_result("fault56", 2, 1, 5);
  endtask

  task automatic test_start_while_busy();
    mode = 2;
    run_sweep(10, 0);
    check_result("start_busy", 2, 1, 5);
    run_sweep(0, 0);
    check_result("restart_done", 2, 1, 5);
  endtask

  task automatic test_reset_mid_sweep();
    mode = 1;
    run_sweep(0, 7);
    n_checks++;
    if (cycles !== 7 || busy !== 1'b0 || done !== 1'b0 || stim_out !== 3'd0 ||
        err_count !== 4'd0 || first_fail_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: got cycles=%0d busy=%b done=%b stim=%0d err=%0d ffv=%b want 7 0 0 0 0 0",
               cycles, busy, done, stim_out, err_count, first_fail_valid);
    end
    mode = 0;
    run_sweep(0, 0);
    check_result("after_reset", 0, 0, 0);
  endtask

  task automatic test_settle_zero();
    int n, bad;
    @(negedge clk);
    s0_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s0_start = 1'b0;
    n = 0;
    bad = 0;
    while (s0_busy === 1'b1 && n < 100) begin
      if (int'(s0_stim) != n) bad++;
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (n !== 8 || bad !== 0) begin
      n_errors++;
      $display("FAIL settle0_walk: got cycles=%0d bad=%0d want 8 0", n, bad);
    end
    n_checks++;
    if (s0_done !== 1'b1 || s0_pass !== 1'b1 || s0_err !== 4'd0 || s0_ffv !== 1'b0) begin
      n_errors++;
      $display("FAIL settle0_result: got done=%b pass=%b err=%0d ffv=%b want 1 1 0 0",
               s0_done, s0_pass, s0_err, s0_ffv);
    end
  endtask

  initial begin
    mode = 0;
    test_reset();
    test_majority();
    test_inverted();
    test_fault_5_6();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_settle_zero();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
